plb_adc_capture: RTL and testbench

Receive-side counterpart of the PLB DAC output core. Drives the conversion clock and power-down pin of an external 10-bit pipelined parallel ADC. Captures each sample with its over-range flag and buffers it in a 16-entry FIFO. The PLB user-logic register file reads samples through a one-cycle request/valid handshake.

---
 rtl/plb_adc_capture.sv | 200 ++++++++++++++++++++
 tb/tb_plb_adc_capture.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plb_adc_capture.sv
// plb_adc_capture
// Drives the conversion clock and power-down pin of an external pipelined
// parallel ADC, discards the pipeline-fill samples after each enable, and
// buffers {OTR, sample} words in a small FIFO that the register file pops
// through a one-cycle request / next-cycle valid handshake.

module plb_adc_capture #(
   parameter int DATA_WIDTH = 10,
   parameter int FIFO_AW    = 4,
   parameter int CLK_DIV    = 4,
   parameter int PIPE_LAT   = 5
) (
   input  logic                  Bus2IP_Clk,
   input  logic                  Bus2IP_Reset,
   input  logic [0:DATA_WIDTH-1] S_Data_pin,
   input  logic                  S_OTR_pin,
   output logic                  S_Clkin_pin,
   output logic                  S_PWRDN_pin,
   input  logic                  ctrl_enable,
   input  logic                  rd_req,
   output logic [DATA_WIDTH:0]   rd_data,
   output logic                  rd_valid,
   output logic [FIFO_AW:0]      fifo_count,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic                  overflow,
   input  logic                  clr_overflow
);

   localparam int DEPTH = 2**FIFO_AW;
   localparam int CW    = $clog2(CLK_DIV);
   localparam int DCW   = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

   localparam logic [CW-1:0]    CNT_MAX    = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0]    CNT_HALF   = CW'(CLK_DIV / 2);
   localparam logic [DCW-1:0]   DISC_LOAD  = DCW'(PIPE_LAT);
   localparam logic [DCW-1:0]   DISC_LAST  = DCW'(1);
   localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WARMUP,
      ST_RUN
   } state_t;

   state_t state_q, state_d;

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [DCW-1:0]      disc_q, disc_d;
   logic                clkin_q, clkin_d;
   logic                pwrdn_q, pwrdn_d;
   logic                strobe;

   logic [DATA_WIDTH:0] in_q, in_d;
   logic [DATA_WIDTH:0] mem_q [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]    count_q, count_d;
   logic                empty_q, empty_d;
   logic                full_q, full_d;
   logic [DATA_WIDTH:0] rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic                ovf_q, ovf_d;
   logic                wr_req, pop, push, drop;

   // State register: capture state and the remaining pipeline-fill discards
   always_ff @(posedge Bus2IP_Clk) begin
      if (Bus2IP_Reset) begin
         state_q <= ST_IDLE;
         disc_q  <= '0;
      end else begin
         state_q <= state_d;
         disc_q  <= disc_d;
      end
   end

   // Next state: warm up for the pipeline latency, then run; disable always wins
   always_comb begin
      state_d = state_q;
      disc_d  = disc_q;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_enable) begin
               state_d = (PIPE_LAT == 0) ? ST_RUN : ST_WARMUP;
               disc_d  = DISC_LOAD;
            end
         end
         ST_WARMUP: begin
            if (strobe) begin
               disc_d = disc_q - 1'b1;
               if (disc_q == DISC_LAST) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (!ctrl_enable) begin
         state_d = ST_IDLE;
      end
   end

   // Outputs: divider count, sample strobe, and next values of the ADC pins
   always_comb begin
      strobe = (state_q != ST_IDLE) && (cnt_q == CNT_MAX);
      if ((state_d == ST_IDLE) || (state_q == ST_IDLE) || (cnt_q == CNT_MAX)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      pwrdn_d = (state_d == ST_IDLE);
      clkin_d = (state_d != ST_IDLE) && (cnt_d < CNT_HALF);
   end

   // Divider and ADC pin registers; the pins reflect the count of the same cycle
   always_ff @(posedge Bus2IP_Clk) begin
      if (Bus2IP_Reset) begin
         cnt_q   <= '0;
         clkin_q <= 1'b0;
         pwrdn_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         clkin_q <= clkin_d;
         pwrdn_q <= pwrdn_d;
      end
   end

   // FIFO control: write on RUN strobes, pop on request, drop only when full without a pop
   always_comb begin
      in_d   = {S_OTR_pin, S_Data_pin};
      wr_req = strobe && (state_q == ST_RUN);
      pop    = rd_req && (count_q != '0);
      push   = wr_req && ((count_q != COUNT_FULL) || pop);
      drop   = wr_req && (count_q == COUNT_FULL) && !pop;

      wr_ptr_d = push ? (wr_ptr_q + 1'b1) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + 1'b1) : rd_ptr_q;

      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      empty_d = (count_d == '0);
      full_d  = (count_d == COUNT_FULL);

      rd_data_d  = pop ? mem_q[rd_ptr_q] : rd_data_q;
      rd_valid_d = pop;

      ovf_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : ovf_q);
   end

   // Input capture, FIFO bookkeeping and read-port registers
   always_ff @(posedge Bus2IP_Clk) begin
      if (Bus2IP_Reset) begin
         in_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         in_q       <= in_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         ovf_q      <= ovf_d;
      end
   end

   // Sample storage; stale contents are harmless because the pointers reset
   always_ff @(posedge Bus2IP_Clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_q;
      end
   end

   assign S_Clkin_pin = clkin_q;
   assign S_PWRDN_pin = pwrdn_q;
   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign fifo_count  = count_q;
   assign fifo_empty  = empty_q;
   assign fifo_full   = full_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_plb_adc_capture.sv
// tb_plb_adc_capture
// Drives ADC data one conversion period at a time, predicts which samples
// are captured, and checks popped words against a queue of expected words.

module tb_plb_adc_capture;

   logic        Bus2IP_Clk;
   logic        Bus2IP_Reset;
   logic [0:9]  S_Data_pin;
   logic        S_OTR_pin;
   logic        S_Clkin_pin;
   logic        S_PWRDN_pin;
   logic        ctrl_enable;
   logic        rd_req;
   logic [10:0] rd_data;
   logic        rd_valid;
   logic [4:0]  fifo_count;
   logic        fifo_empty;
   logic        fifo_full;
   logic        overflow;
   logic        clr_overflow;

   typedef struct {
      logic [9:0]  data;
      logic        otr;
      logic [10:0] word;
   } vec_t;

   vec_t        vecs [5];
   logic [10:0] sb_q [$];
   logic [10:0] last_word;
   int          compared;
   int          mismatched;

   plb_adc_capture dut (
      .Bus2IP_Clk   (Bus2IP_Clk),
      .Bus2IP_Reset (Bus2IP_Reset),
      .S_Data_pin   (S_Data_pin),
      .S_OTR_pin    (S_OTR_pin),
      .S_Clkin_pin  (S_Clkin_pin),
      .S_PWRDN_pin  (S_PWRDN_pin),
      .ctrl_enable  (ctrl_enable),
      .rd_req       (rd_req),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .fifo_count   (fifo_count),
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   // Free-running system clock
   initial begin
      Bus2IP_Clk = 1'b0;
      forever #5 Bus2IP_Clk = ~Bus2IP_Clk;
   end

   task automatic tick();
      @(posedge Bus2IP_Clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkRead(input string name);
      logic [10:0] exp_word;
      checkOutput({name, " rd_valid"}, 32'(rd_valid), 32'd1);
      if (sb_q.size() == 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL %s scoreboard: got 0x%0h, expected no pending word", name, rd_data);
      end else begin
         exp_word = sb_q.pop_front();
         checkOutput({name, " rd_data"}, 32'(rd_data), 32'(exp_word));
         last_word = exp_word;
      end
   endtask

   // One ADC period; clr_tick/rd_tick pulse those inputs into the given edge (4 = strobe edge)
   task automatic applyStimulus(input logic [9:0] data, input logic otr, input int clr_tick, input int rd_tick);
      S_Data_pin = data;
      S_OTR_pin  = otr;
      for (int i = 1; i <= 4; i++) begin
         clr_overflow = (i == clr_tick);
         rd_req       = (i == rd_tick);
         tick();
         clr_overflow = 1'b0;
         rd_req       = 1'b0;
         checkOutput("S_Clkin_pin", 32'(S_Clkin_pin), 32'((i == 1) || (i == 4)));
         if (i == rd_tick) checkRead("strobe read");
      end
   endtask

   task automatic readBurst(input int n);
      rd_req = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         if (i == n - 1) rd_req = 1'b0;
         checkRead("burst");
      end
      tick();
      checkOutput("rd_valid after burst", 32'(rd_valid), 32'd0);
      checkOutput("rd_data hold", 32'(rd_data), 32'(last_word));
   endtask

   task automatic enableCapture();
      ctrl_enable = 1'b1;
      tick();
      checkOutput("PWRDN on enable", 32'(S_PWRDN_pin), 32'd0);
      checkOutput("Clkin on enable", 32'(S_Clkin_pin), 32'd1);
   endtask

   task automatic discardPeriods();
      for (int k = 0; k < 5; k++) begin
         applyStimulus(10'(10'h2A5 + k), 1'b1, 0, 0);
         checkOutput("discard count", 32'(fifo_count), 32'd0);
      end
   endtask

   // Main test sequence
   initial begin
      compared     = 0;
      mismatched   = 0;
      last_word    = '0;
      vecs[0]      = '{10'h3FF, 1'b1, 11'h7FF};
      vecs[1]      = '{10'h155, 1'b0, 11'h155};
      vecs[2]      = '{10'h000, 1'b1, 11'h400};
      vecs[3]      = '{10'h2AA, 1'b0, 11'h2AA};
      vecs[4]      = '{10'h201, 1'b1, 11'h601};

      Bus2IP_Reset = 1'b1;
      ctrl_enable  = 1'b0;
      rd_req       = 1'b0;
      clr_overflow = 1'b0;
      S_Data_pin   = '0;
      S_OTR_pin    = 1'b0;

      // Reset state
      repeat (3) tick();
      checkOutput("reset PWRDN", 32'(S_PWRDN_pin), 32'd1);
      checkOutput("reset Clkin", 32'(S_Clkin_pin), 32'd0);
      checkOutput("reset empty", 32'(fifo_empty), 32'd1);
      checkOutput("reset full", 32'(fifo_full), 32'd0);
      checkOutput("reset count", 32'(fifo_count), 32'd0);
      checkOutput("reset overflow", 32'(overflow), 32'd0);
      checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("reset rd_data", 32'(rd_data), 32'd0);
      Bus2IP_Reset = 1'b0;
      tick();
      checkOutput("idle PWRDN", 32'(S_PWRDN_pin), 32'd1);

      // Warmup discard with a ramp; the sixth strobe is the first write
      enableCapture();
      for (int k = 1; k <= 8; k++) begin
         if (k >= 6) sb_q.push_back({1'b0, 10'(k - 1)});
         applyStimulus(10'(k - 1), 1'b0, 0, 0);
         checkOutput("warmup count", 32'(fifo_count), 32'((k > 5) ? (k - 5) : 0));
      end

      // Disable with three samples held, then read them back
      ctrl_enable = 1'b0;
      tick();
      checkOutput("disable PWRDN", 32'(S_PWRDN_pin), 32'd1);
      checkOutput("disable Clkin", 32'(S_Clkin_pin), 32'd0);
      checkOutput("disable count", 32'(fifo_count), 32'd3);
      readBurst(1);
      readBurst(2);
      checkOutput("drained empty", 32'(fifo_empty), 32'd1);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      checkOutput("empty rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("empty rd_data hold", 32'(rd_data), 32'(last_word));

      // Re-enable repeats warmup; OTR passthrough table
      enableCapture();
      discardPeriods();
      for (int i = 0; i < 5; i++) begin
         sb_q.push_back(vecs[i].word);
         applyStimulus(vecs[i].data, vecs[i].otr, 0, 0);
         checkOutput("table count", 32'(fifo_count), 32'(i + 1));
      end
      ctrl_enable = 1'b0;
      tick();
      readBurst(5);

      // Fill to full, then overflow on the 17th strobe
      enableCapture();
      discardPeriods();
      for (int i = 0; i < 16; i++) begin
         sb_q.push_back({1'b0, 10'(256 + i)});
         applyStimulus(10'(256 + i), 1'b0, 0, 0);
         checkOutput("fill count", 32'(fifo_count), 32'(i + 1));
      end
      checkOutput("fill full", 32'(fifo_full), 32'd1);
      checkOutput("fill overflow", 32'(overflow), 32'd0);
      applyStimulus(10'h3C3, 1'b1, 0, 0);
      checkOutput("drop overflow", 32'(overflow), 32'd1);
      checkOutput("drop count", 32'(fifo_count), 32'd16);
      checkOutput("drop full", 32'(fifo_full), 32'd1);

      // Clear, then pop on the strobe edge while full
      sb_q.push_back({1'b0, 10'h0F0});
      applyStimulus(10'h0F0, 1'b0, 2, 4);
      checkOutput("pop+write count", 32'(fifo_count), 32'd16);
      checkOutput("pop+write overflow", 32'(overflow), 32'd0);
      checkOutput("pop+write full", 32'(fifo_full), 32'd1);

      // Drop and clear on the same edge
      applyStimulus(10'h333, 1'b0, 4, 0);
      checkOutput("drop+clr overflow", 32'(overflow), 32'd1);
      checkOutput("drop+clr count", 32'(fifo_count), 32'd16);

      // Drain in order, then clear the sticky flag
      ctrl_enable = 1'b0;
      tick();
      checkOutput("held count", 32'(fifo_count), 32'd16);
      readBurst(16);
      checkOutput("drain empty", 32'(fifo_empty), 32'd1);
      checkOutput("overflow kept", 32'(overflow), 32'd1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      checkOutput("clr overflow", 32'(overflow), 32'd0);

      // Reset mid-run abandons buffered samples
      enableCapture();
      discardPeriods();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(10'(64 + i), 1'b0, 0, 0);
      end
      checkOutput("pre-reset count", 32'(fifo_count), 32'd3);
      Bus2IP_Reset = 1'b1;
      tick();
      checkOutput("mid reset count", 32'(fifo_count), 32'd0);
      checkOutput("mid reset empty", 32'(fifo_empty), 32'd1);
      checkOutput("mid reset PWRDN", 32'(S_PWRDN_pin), 32'd1);
      checkOutput("mid reset Clkin", 32'(S_Clkin_pin), 32'd0);
      checkOutput("mid reset rd_data", 32'(rd_data), 32'd0);
      Bus2IP_Reset = 1'b0;
      ctrl_enable  = 1'b0;
      sb_q.delete();
      last_word = '0;
      tick();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      checkOutput("post-reset rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("post-reset rd_data", 32'(rd_data), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
